// File: rtl/if_prefetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction prefetch unit.
package if_prefetch_pkg;

    localparam logic        RstEnable     = 1'b0;
    localparam int          InstAddrBus   = 32;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam int          PrefetchDepth = 4;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [31:0]            inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of {pc, inst} entries with push/pop and a
// flush that overrides both.
module prefetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = PrefetchDepth,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/empty already mark it stale.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: sequential fetch from a combinational ROM into a small FIFO,
// jump redirect flushes. Optional starvation counter under IF_PERF_CNT_EN.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = PrefetchDepth,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [31:0]            rom_data_i,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    output logic                   inst_valid_o,
    output logic [31:0]            inst_o,
    output logic [InstAddrBus-1:0] inst_addr_o,
    input  logic                   inst_ready_i
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]            starve_cnt_o
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [InstAddrBus-1:0] fetch_pc;
    fetch_entry_t           wr_entry;
    fetch_entry_t           head;
    logic [AW:0]            fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push_en;
    logic                   pop_en;

    // Push decision follows the registered count; a jump always suppresses it.
    assign push_en    = !jump_flag_i && (fifo_count < FULL_CNT);
    assign pop_en     = inst_valid_o && inst_ready_i;
    assign wr_entry   = '{pc: fetch_pc, inst: rom_data_i};
    assign rom_addr_o = fetch_pc;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_en),
        .pop      (pop_en),
        .flush    (jump_flag_i),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            fetch_pc <= RESET_PC;
        end else if (jump_flag_i) begin
            fetch_pc <= {jump_addr_i[InstAddrBus-1:2], 2'b00};
        end else if (push_en) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = INST_NOP;
        inst_addr_o  = ZeroWord;
        if (!fifo_empty && !jump_flag_i) begin
            inst_valid_o = 1'b1;
            inst_o       = head.inst;
            inst_addr_o  = head.pc;
        end
    end

    full_matches_count: assert property (@(posedge clk) fifo_full == (fifo_count == FULL_CNT));

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            starve_cnt_o <= '0;
        end else if (inst_ready_i && !inst_valid_o && !jump_flag_i && (starve_cnt_o != 32'hFFFF_FFFF)) begin
            starve_cnt_o <= starve_cnt_o + 32'd1;
        end
    end
`endif

endmodule
